// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter (open-drain, filtered)
// Rev 1.0
// ============================================================================
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 12000,
  parameter int TIMEOUT_CYC = 2000000,
  parameter int FILTER_LEN  = 8
) (
  input  logic       Reloj,
  input  logic       RST,
  input  logic       WR,
  input  logic [7:0] DATA_TX,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [20:0] INH_LAST = 21'(INHIBIT_CYC - 1);
  localparam logic [20:0] TO_LAST  = 21'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [20:0]             cnt_q, cnt_d;
  logic [3:0]              n_q, n_d;
  logic [9:0]              frame_q, frame_d;
  logic                    c_oe_q, c_oe_d;
  logic                    d_oe_q, d_oe_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ack_ok_q, ack_ok_d;
  logic [FILTER_LEN-1:0]   c_sh_q, c_sh_d;
  logic [FILTER_LEN-1:0]   d_sh_q, d_sh_d;
  logic                    c_f_q, c_f_d;
  logic                    d_f_q, d_f_d;
  logic                    w_fall_c;
  logic [3:0]              w_next_idx;

  // Filtered level only moves once the whole window agrees.
  always_comb begin
    c_sh_d   = {c_sh_q[FILTER_LEN-2:0], ps2c_in};
    d_sh_d   = {d_sh_q[FILTER_LEN-2:0], ps2d_in};
    c_f_d    = (&c_sh_q) ? 1'b1 : ((~|c_sh_q) ? 1'b0 : c_f_q);
    d_f_d    = (&d_sh_q) ? 1'b1 : ((~|d_sh_q) ? 1'b0 : d_f_q);
    w_fall_c = c_f_q & ~|c_sh_q;
  end

  assign w_next_idx = n_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    frame_d  = frame_q;
    c_oe_d   = c_oe_q;
    d_oe_d   = d_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ack_ok_d = ack_ok_q;
    unique case (state_q)
      IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        busy_d = 1'b0;
        if (WR) begin
          frame_d = {1'b1, ~^DATA_TX, DATA_TX};
          n_d     = 4'd0;
          cnt_d   = 21'd0;
          busy_d  = 1'b1;
          c_oe_d  = 1'b1;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = 21'd0;
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 21'd1;
        end
      end
      START, DATA, ACK, WAIT_IDLE: begin
        // Timeout takes priority over any device edge in the same cycle.
        if (cnt_q == TO_LAST) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 21'd1;
          if (state_q == START) begin
            if (w_fall_c) begin
              n_d     = 4'd0;
              d_oe_d  = ~frame_q[0];
              state_d = DATA;
            end
          end else if (state_q == DATA) begin
            if (w_fall_c) begin
              if (n_q == 4'd9) begin
                n_d      = 4'd10;
                ack_ok_d = ~d_f_q;
                state_d  = ACK;
              end else begin
                n_d    = w_next_idx;
                d_oe_d = ~frame_q[w_next_idx];
              end
            end
          end else if (state_q == ACK) begin
            state_d = WAIT_IDLE;
          end else if (c_f_q && d_f_q) begin
            busy_d  = 1'b0;
            done_d  = ack_ok_q;
            err_d   = ~ack_ok_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Reloj or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= 21'd0;
      n_q      <= 4'd0;
      frame_q  <= 10'd0;
      c_oe_q   <= 1'b0;
      d_oe_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ack_ok_q <= 1'b0;
      c_sh_q   <= '1;
      d_sh_q   <= '1;
      c_f_q    <= 1'b1;
      d_f_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      frame_q  <= frame_d;
      c_oe_q   <= c_oe_d;
      d_oe_q   <= d_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ack_ok_q <= ack_ok_d;
      c_sh_q   <= c_sh_d;
      d_sh_q   <= d_sh_d;
      c_f_q    <= c_f_d;
      d_f_q    <= d_f_d;
    end
  end

  assign ps2c_oe = c_oe_q;
  assign ps2d_oe = d_oe_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_tx : PS/2 host transmitter bench with a clocking device model
// Rev 1.0
// ============================================================================
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int TO  = 3000;
  localparam int FL  = 8;
  localparam int H   = 40;

  typedef struct {
    logic [7:0] data;
    bit         ack;
  } exp_t;

  logic       Reloj = 1'b0;
  logic       RST;
  logic       WR;
  logic [7:0] DATA_TX;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe, BUSY, DONE, ERR;
  logic       dev_c, dev_d, glitch_c;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0, busy_drop = 0;
  int   inh_run = 0, inh_last = 0;
  bit   in_xfer = 0;

  assign ps2c_in = ~(ps2c_oe | dev_c | glitch_c);
  assign ps2d_in = ~(ps2d_oe | dev_d);

  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILTER_LEN(FL)) dut (
    .Reloj   (Reloj),
    .RST     (RST),
    .WR      (WR),
    .DATA_TX (DATA_TX),
    .ps2c_in (ps2c_in),
    .ps2d_in (ps2d_in),
    .ps2c_oe (ps2c_oe),
    .ps2d_oe (ps2d_oe),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 Reloj = ~Reloj;

  always @(negedge Reloj) begin
    if (DONE === 1'b1) done_cnt++;
    if (ERR === 1'b1) err_cnt++;
    if (DONE === 1'b1 && ERR === 1'b1) both_cnt++;
    if (in_xfer && BUSY !== 1'b1) busy_drop++;
    if (ps2c_oe === 1'b1) inh_run++;
    else if (inh_run != 0) begin
      inh_last = inh_run;
      inh_run  = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Reloj);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1);
    WR      = 1'b1;
    DATA_TX = d;
    cyc(1);
    WR      = 1'b0;
  endtask

  // Device side: waits for the request-to-send, then clocks 11 pulses,
  // sampling ps2d on each rising edge and pulling ps2d low for the ACK.
  task automatic dev_receive(input bit glitch, input int abort_k, output bit aborted);
    exp_t       e;
    logic [9:0] rx;
    bit         found;
    aborted = 1'b0;
    rx      = '0;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e     = sb.pop_front();
    found = 1'b0;
    for (int i = 0; i < INH + 200 && !found; i++) begin
      cyc(1);
      if (ps2c_oe === 1'b0 && ps2d_oe === 1'b1) found = 1'b1;
    end
    chk("start_seen", found, 1);
    if (!found) return;
    in_xfer = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cyc(H / 2);
      if (k == 0) chk("start_bit", ps2d_in, 0);
      if (k == 10) dev_d = e.ack;
      if (glitch && k == 4) begin
        glitch_c = 1'b1;
        cyc(3);
        glitch_c = 1'b0;
        cyc(H / 2 - 3);
      end else begin
        cyc(H / 2);
      end
      dev_c = 1'b1;
      cyc(H);
      dev_c = 1'b0;
      if (k < 10) rx[k] = ps2d_in;
      if (k == abort_k) begin
        aborted = 1'b1;
        in_xfer = 1'b0;
        return;
      end
    end
    dev_d   = 1'b0;
    in_xfer = 1'b0;
    chk("rx_data", rx[7:0], e.data);
    chk("rx_parity", rx[8], ($countones(e.data) % 2 == 0) ? 1 : 0);
    chk("rx_stop", rx[9], 1);
  endtask

  task automatic wait_result(input bit exp_done);
    int d0, e0, i;
    d0 = done_cnt;
    e0 = err_cnt;
    i  = 0;
    while (done_cnt == d0 && err_cnt == e0 && i < 500) begin
      cyc(1);
      i++;
    end
    cyc(2);
    chk("done_pulses", done_cnt - d0, exp_done ? 1 : 0);
    chk("err_pulses", err_cnt - e0, exp_done ? 0 : 1);
    chk("busy_after", BUSY, 0);
  endtask

  initial begin
    bit ab;
    int n;
    int d0;
    RST = 1'b0; WR = 1'b0; DATA_TX = 8'h00;
    dev_c = 1'b0; dev_d = 1'b0; glitch_c = 1'b0;
    cyc(3);
    chk("rst_c_oe", ps2c_oe, 0);
    chk("rst_d_oe", ps2d_oe, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    RST = 1'b1;
    cyc(3);

    // 0xED with ACK
    sb.push_back('{8'hED, 1'b1});
    send(8'hED);
    cyc(1);
    chk("busy_on_wr", BUSY, 1);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b1);
    chk("inhibit_len", inh_last, INH);

    // parity boundary: zero ones vs one one
    sb.push_back('{8'h00, 1'b1});
    send(8'h00);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b1);
    sb.push_back('{8'h01, 1'b1});
    send(8'h01);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b1);

    // no ACK from device, then a normal transfer is still accepted
    sb.push_back('{8'hA5, 1'b0});
    send(8'hA5);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b0);
    sb.push_back('{8'h3C, 1'b1});
    send(8'h3C);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b1);

    // device never clocks: timeout counted from START entry
    send(8'h55);
    n = 0;
    while (!(ps2c_oe === 1'b0 && ps2d_oe === 1'b1) && n < INH + 200) begin
      cyc(1);
      n++;
    end
    chk("to_start_seen", (ps2d_oe === 1'b1) ? 1 : 0, 1);
    n = 0;
    while (ERR !== 1'b1 && n < 2 * TO) begin
      cyc(1);
      n++;
    end
    chk("timeout_len", n, TO);
    chk("to_c_oe", ps2c_oe, 0);
    chk("to_d_oe", ps2d_oe, 0);
    chk("to_busy", BUSY, 0);
    cyc(5);

    // WR while busy is ignored
    sb.push_back('{8'hED, 1'b1});
    send(8'hED);
    fork
      dev_receive(1'b0, -1, ab);
      begin
        cyc(INH + 300);
        WR      = 1'b1;
        DATA_TX = 8'hFF;
        cyc(1);
        WR      = 1'b0;
      end
    join
    wait_result(1'b1);
    d0 = done_cnt;
    cyc(INH + 100);
    chk("no_extra_done", done_cnt - d0, 0);
    chk("no_restart", BUSY, 0);

    // async reset mid-frame, then a clean transfer
    sb.push_back('{8'h00, 1'b1});
    send(8'h00);
    dev_receive(1'b0, 3, ab);
    chk("aborted", ab, 1);
    chk("pre_rst_busy", BUSY, 1);
    chk("pre_rst_d_oe", ps2d_oe, 1);
    @(negedge Reloj);
    #2 RST = 1'b0;
    #1;
    chk("arst_c_oe", ps2c_oe, 0);
    chk("arst_d_oe", ps2d_oe, 0);
    chk("arst_busy", BUSY, 0);
    cyc(4);
    RST = 1'b1;
    cyc(4);
    sb.push_back('{8'hF4, 1'b1});
    send(8'hF4);
    dev_receive(1'b0, -1, ab);
    wait_result(1'b1);

    // short ps2c glitch must not advance the bit counter
    sb.push_back('{8'h5A, 1'b1});
    send(8'h5A);
    dev_receive(1'b1, -1, ab);
    wait_result(1'b1);

    chk("done_err_exclusive", both_cnt, 0);
    chk("busy_held", busy_drop, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
